// File: rtl/mem_loader_pkg.sv
// loader_pkg: shared definitions for the boot-time program loader.
//   state_t       - loader session state encoding
//   LEN_256_CODE  - length byte value that selects a full 256-byte load
//   CSUM_OK       - required value of (sum of program bytes + checksum byte)
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [7:0] LEN_256_CODE = 8'h00;
  localparam logic [7:0] CSUM_OK      = 8'h00;

endpackage : loader_pkg

// File: rtl/mem_loader_if.sv
// mem_loader_if: stream input handshake plus memory-side bus of the loader.
//   in_valid/in_data/in_ready - byte stream into the loader
//   mem_en/mem_memwrite/mem_adr/mem_writedata - bus toward external memory
// slave  : the loader (consumes stream, drives memory bus)
// master : the environment (stream source, memory)
interface mem_loader_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_BITS = 8
);
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic                 mem_en;
  logic                 mem_memwrite;
  logic [ADDR_BITS-1:0] mem_adr;
  logic [WIDTH-1:0]     mem_writedata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_en, mem_memwrite, mem_adr, mem_writedata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_en, mem_memwrite, mem_adr, mem_writedata
  );
endinterface : mem_loader_if

// File: rtl/mem_loader.sv
// mem_loader: boot-time program loader in front of a 256-byte memory.
// Holds the processor in reset, accepts length / N program bytes / checksum
// over a valid/ready stream, writes the program to addresses 0..N-1 and
// releases the processor only on a good checksum. Outside a session the
// processor's memory signals pass straight through.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start               - single-cycle pulse beginning a load session
//   cpu_memwrite/cpu_adr/cpu_writedata - processor memory bus (pass-through)
//   bus (slave)         - stream handshake and memory bus
//   cpu_reset           - processor reset, high until a program is loaded
//   busy/done/err       - session status
module mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cpu_memwrite,
  input  logic [ADDR_BITS-1:0] cpu_adr,
  input  logic [WIDTH-1:0]     cpu_writedata,
  mem_loader_if.slave          bus,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned REM_W = ADDR_BITS + 1;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic [REM_W-1:0]     remaining_q, remaining_d;
  logic                 cpu_reset_q, cpu_reset_d;

  logic                 accept;
  logic [WIDTH-1:0]     sum_plus_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      sum_q       <= '0;
      remaining_q <= '0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sum_q       <= sum_d;
      remaining_q <= remaining_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign sum_plus_in = sum_q + bus.in_data;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sum_d       = sum_q;
    remaining_d = remaining_q;
    cpu_reset_d = cpu_reset_q;

    bus.in_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;

    bus.mem_memwrite  = cpu_memwrite;
    bus.mem_adr       = cpu_adr;
    bus.mem_writedata = cpu_writedata;

    accept = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LEN;
      end

      ST_LEN: begin
        bus.in_ready      = 1'b1;
        busy              = 1'b1;
        bus.mem_memwrite  = 1'b0;
        bus.mem_adr       = addr_q;
        bus.mem_writedata = '0;
        accept            = bus.in_valid;
        if (accept) begin
          // Length code zero means a full address space load.
          remaining_d = (bus.in_data == WIDTH'(LEN_256_CODE))
                        ? REM_W'(1 << ADDR_BITS)
                        : REM_W'(bus.in_data);
          addr_d  = '0;
          sum_d   = '0;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        bus.in_ready      = 1'b1;
        busy              = 1'b1;
        // Write is combinational; memory captures on the falling edge.
        bus.mem_memwrite  = bus.in_valid;
        bus.mem_adr       = addr_q;
        bus.mem_writedata = bus.in_data;
        accept            = bus.in_valid;
        if (accept) begin
          addr_d      = addr_q + 1'b1;
          sum_d       = sum_plus_in;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == REM_W'(1)) state_d = ST_CSUM;
        end
      end

      ST_CSUM: begin
        bus.in_ready      = 1'b1;
        busy              = 1'b1;
        bus.mem_memwrite  = 1'b0;
        bus.mem_adr       = addr_q;
        bus.mem_writedata = '0;
        accept            = bus.in_valid;
        if (accept) begin
          if (sum_plus_in == WIDTH'(CSUM_OK)) begin
            state_d     = ST_DONE;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = ST_ERR;
          end
        end
      end

      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d     = ST_LEN;
          cpu_reset_d = 1'b1;
        end
      end

      ST_ERR: begin
        err = 1'b1;
        if (start) begin
          state_d     = ST_LEN;
          cpu_reset_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_en = 1'b1;
  assign cpu_reset  = cpu_reset_q;

endmodule : mem_loader

// File: tb/tb_mem_loader.sv
// tb_mem_loader: scoreboard bench for mem_loader. Expected memory writes are
// queued as data bytes are driven and popped when the memory bus writes on
// the falling edge; a behavioural 256-byte memory holds the written image.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cpu_memwrite;
  logic [7:0] cpu_adr;
  logic [7:0] cpu_writedata;
  logic       cpu_reset, busy, done, err;

  mem_loader_if #(.WIDTH(8), .ADDR_BITS(8)) bus ();

  mem_loader #(.WIDTH(8), .ADDR_BITS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cpu_memwrite (cpu_memwrite),
    .cpu_adr      (cpu_adr),
    .cpu_writedata(cpu_writedata),
    .bus          (bus.slave),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0]  mem_model [256];
  logic [15:0] sb_q [$];
  logic [7:0]  exp_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Memory: captures writes on the falling edge; every write must be expected.
  always @(negedge clk) begin
    if (bus.mem_en && bus.mem_memwrite) begin
      check("wr_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        logic [15:0] e;
        e = sb_q.pop_front();
        check("wr_addr", 32'(bus.mem_adr), 32'(e[15:8]));
        check("wr_data", 32'(bus.mem_writedata), 32'(e[7:0]));
      end
      mem_model[bus.mem_adr] <= bus.mem_writedata;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit is_data);
    logic rdy;
    int   n;
    if (is_data) begin
      sb_q.push_back({exp_addr, b});
      exp_addr = exp_addr + 8'd1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) check("rdy_timeout", 32'(rdy), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic good_load(input int stall);
    exp_addr = 8'h00;
    send_byte(8'h03, 1'b0); idle_cycles(stall);
    send_byte(8'h20, 1'b1); idle_cycles(stall);
    send_byte(8'h01, 1'b1); idle_cycles(stall);
    send_byte(8'h05, 1'b1); idle_cycles(stall);
    check("pre_csum_cpu_reset", 32'(cpu_reset), 32'd1);
    send_byte(8'hDA, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    cpu_memwrite  = 1'b0;
    cpu_adr       = 8'h5A;
    cpu_writedata = 8'h33;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'hEE;
    idle_cycles(2);

    // Reset state and pass-through
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mem_en", 32'(bus.mem_en), 32'd1);
    check("pt_adr", 32'(bus.mem_adr), 32'h5A);
    check("pt_wdata", 32'(bus.mem_writedata), 32'h33);
    reset = 1'b0;
    idle_cycles(1);
    sb_q.push_back({8'h5A, 8'h33});
    cpu_memwrite = 1'b1;
    idle_cycles(1);
    cpu_memwrite = 1'b0;
    check("pt_mem", 32'(mem_model[8'h5A]), 32'h33);

    // Good load, in_valid already high when start arrives
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h03;
    pulse_start();
    check("len_busy", 32'(busy), 32'd1);
    check("len_ready", 32'(bus.in_ready), 32'd1);
    check("len_wdata", 32'(bus.mem_writedata), 32'h00);
    check("len_memwrite", 32'(bus.mem_memwrite), 32'd0);
    good_load(0);
    check("good_done", 32'(done), 32'd1);
    check("good_cpu_reset", 32'(cpu_reset), 32'd0);
    check("good_busy", 32'(busy), 32'd0);
    check("good_mem0", 32'(mem_model[0]), 32'h20);
    check("good_mem1", 32'(mem_model[1]), 32'h01);
    check("good_mem2", 32'(mem_model[2]), 32'h05);
    cpu_adr = 8'h01;
    #1;
    check("rd_adr", 32'(bus.mem_adr), 32'h01);
    check("rd_data", 32'(mem_model[bus.mem_adr]), 32'h01);

    // Start in DONE, then a bad checksum with an ignored mid-session start
    pulse_start();
    check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    exp_addr = 8'h00;
    send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b1);
    pulse_start();
    check("busy_start_ignored", 32'(busy), 32'd1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h00, 1'b0);
    check("bad_err", 32'(err), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_cpu_reset", 32'(cpu_reset), 32'd1);
    check("bad_mem0", 32'(mem_model[0]), 32'hAA);
    check("bad_mem1", 32'(mem_model[1]), 32'h55);
    check("bad_mem2", 32'(mem_model[2]), 32'h05);

    // Stalled good load from ERR
    pulse_start();
    good_load(2);
    check("stall_done", 32'(done), 32'd1);
    check("stall_cpu_reset", 32'(cpu_reset), 32'd0);
    check("stall_mem0", 32'(mem_model[0]), 32'h20);
    check("stall_mem1", 32'(mem_model[1]), 32'h01);
    check("stall_mem2", 32'(mem_model[2]), 32'h05);

    // Length 0 -> 256 bytes
    pulse_start();
    exp_addr = 8'h00;
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b1);
    check("l256_busy_before_csum", 32'(busy), 32'd1);
    send_byte(8'h80, 1'b0);
    check("l256_done", 32'(done), 32'd1);
    begin
      int unsigned bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem_model[i] !== 8'(i)) bad++;
      check("l256_image_errors", bad, 32'd0);
    end
    cpu_adr = 8'h77;
    pulse_start();
    check("l256_addr_wrapped", 32'(bus.mem_adr), 32'h00);

    // Reset during DATA after 2 of 4 bytes
    exp_addr = 8'h00;
    send_byte(8'h04, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    idle_cycles(1);
    reset = 1'b0;
    idle_cycles(1);
    check("mid_rst_idle_busy", 32'(busy), 32'd0);
    check("mid_mem0", 32'(mem_model[0]), 32'h11);
    check("mid_mem1", 32'(mem_model[1]), 32'h22);
    check("mid_mem2", 32'(mem_model[2]), 32'h02);
    check("mid_mem3", 32'(mem_model[3]), 32'h03);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_loader

// File: doc/mem_loader.md
# mem_loader

Boot-time program loader sitting directly upstream of the 256-byte external memory. After reset it holds the processor in reset and accepts a byte stream over a valid/ready handshake: a length byte, N program bytes, and a checksum byte. It writes the program bytes to memory addresses 0..N-1 and releases the processor only if the checksum matches. Outside a load session it passes the processor's memory signals straight through to the memory.

## Interface
- WIDTH, 8, data width of stream and memory bus
- ADDR_BITS, 8, memory address width (256 bytes)

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load session
- in_valid  in  1  stream byte valid
- in_data  in  WIDTH  stream byte
- in_ready  out  1  loader can accept a byte this cycle
- cpu_memwrite  in  1  processor write strobe (pass-through)
- cpu_adr  in  ADDR_BITS  processor address (pass-through)
- cpu_writedata  in  WIDTH  processor write data (pass-through)
- mem_en  out  1  memory enable; constant 1
- mem_memwrite  out  1  memory write strobe
- mem_adr  out  ADDR_BITS  memory address
- mem_writedata  out  WIDTH  memory write data
- cpu_reset  out  1  processor reset; high while the program is not validly loaded
- busy  out  1  load session in progress
- done  out  1  last session completed with a good checksum
- err  out  1  last session ended with a checksum mismatch

## Operation
- States: IDLE, LEN, DATA, CSUM, DONE, ERR. Reset enters IDLE.
- IDLE: start -> LEN.
- DONE/ERR: start -> LEN. cpu_reset reasserts on that edge.
- LEN/DATA/CSUM: start is ignored.
- in_ready = 1 exactly in LEN, DATA, CSUM. A byte is accepted when in_valid && in_ready.
- LEN accept: remaining <= (in_data == 0) ? 256 : in_data (9-bit counter). addr <= 0. sum <= 0. Next state DATA.
- DATA accept: byte is written to address addr. addr <= addr + 1 (8-bit, wraps). sum <= sum + in_data (mod 256). remaining <= remaining - 1. When remaining == 1 -> CSUM.
- CSUM accept: if (sum + in_data) mod 256 == 0 -> DONE, else -> ERR.
- Memory mux:
  - In DATA: mem_memwrite = in_valid, mem_adr = addr, mem_writedata = in_data.
  - In LEN and CSUM: mem_memwrite = 0, mem_adr = addr, mem_writedata = 0.
  - In IDLE/DONE/ERR: mem_memwrite = cpu_memwrite, mem_adr = cpu_adr, mem_writedata = cpu_writedata.
- busy = state in {LEN, DATA, CSUM}. done = (state == DONE). err = (state == ERR).

## Timing
- Reset values: state IDLE, cpu_reset 1, busy 0, done 0, err 0, in_ready 0, addr 0, sum 0, remaining 0.
- Memory-side outputs in IDLE pass the processor signals through; mem_en is 1 throughout.
- Throughput: one byte per clk. A stream stall (in_valid = 0) holds all state.
- Write path is combinational in DATA. Memory captures the write on the falling edge of the same cycle in which the byte is accepted, so latency is half a cycle. in_data must be stable through that falling edge.
- cpu_reset is a registered flop:
  - Cleared on the rising edge that accepts a matching checksum, so it is low from the first cycle in DONE.
  - Set on reset, and on any start from DONE/ERR.
  - Stays 1 in ERR.
- Length 0 loads 256 bytes, with addr wrapping 255 -> 0 after the last write.
- Reset mid-session: returns to IDLE and cpu_reset goes high immediately (asynchronous). Bytes already written remain in memory; no scrub.
- start in IDLE with in_valid already high: the first byte is accepted one cycle later, in LEN.

## Structure
- Shared package loader_pkg holds:
  - state encoding (enumerated localparams);
  - LEN_256_CODE = 8'h00;
  - the checksum rule constant CSUM_OK = 8'h00.
- Single flat module. No sub-module is warranted; the checksum accumulator is one adder and one register.

## Test plan
- Good load: start; stream 03, 20, 01, 05, DA -> memory 0..2 = 20, 01, 05; done = 1; cpu_reset falls in the first DONE cycle; then cpu_adr = 01 reads back 01.
- Bad checksum: stream 02, AA, 55, 00 -> ERR; err = 1; cpu_reset stays 1; memory 0..1 = AA, 55.
- Stalls: same as good load with in_valid deasserted for 2 cycles between every byte -> identical final memory and done. No writes occur during stall cycles.
- Length 0: 00 followed by bytes 00..FF, then checksum 80 -> all 256 locations written, done = 1, addr wrapped to 00.
- Reset during DATA after 2 of 4 bytes -> IDLE next, cpu_reset = 1, busy = 0; locations 0..1 written, 2..3 untouched.
- start asserted while busy -> ignored (session continues unchanged); start in DONE -> LEN, cpu_reset = 1, done = 0.
